ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
- Decode-to-execute pipeline register of the RV32 core.
- Takes the decoded instruction plus register-file read data and resolves operand forwarding from the EX and MEM stages. Registers the final ALU op and both ALU operands; the ALU consumes these outputs combinationally.
- Detects load-use hazards and inserts a one-cycle bubble.
- Uses valid/ready handshakes on both sides and supports a synchronous flush on branch redirect.

Parameters:
XLEN, 32, datapath width
REG_ADDR_W, 5, register index width
ALU_OP_W, 4, width of ALU op code (encodings from defs.sv)

Ports:
clk_i  in  1  core clock, all state on rising edge
rst_i  in  1  synchronous active-high reset
flush_i  in  1  kill EX-slot contents and the offered ID instruction
id_valid_i  in  1  decode offers an instruction
id_ready_o  out  1  stage accepts the decode instruction this cycle
id_alu_op_i  in  ALU_OP_W  ALU operation code
id_pc_i  in  XLEN  instruction PC
id_rs1_i / id_rs2_i  in  REG_ADDR_W  source register indices
id_uses_rs1_i / id_uses_rs2_i  in  1  source operand is actually read
id_rs1_data_i / id_rs2_data_i  in  XLEN  register-file read data (write-through already applied for WB)
id_imm_i  in  XLEN  sign-extended immediate
id_a_pc_i  in  1  operand A = PC instead of rs1
id_b_imm_i  in  1  operand B = immediate instead of rs2
id_rd_i  in  REG_ADDR_W  destination register
id_reg_write_i  in  1  instruction writes rd
id_is_load_i  in  1  instruction is a load
ex_result_i  in  XLEN  current ALU output (instruction held in this stage)
mem_fwd_valid_i  in  1  MEM-stage instruction writes a register, result final
mem_rd_i  in  REG_ADDR_W  MEM-stage destination
mem_result_i  in  XLEN  MEM-stage result
ex_valid_o  out  1  EX slot holds a live instruction
ex_ready_i  in  1  downstream accepts the EX instruction
alu_op_o  out  ALU_OP_W  registered ALU op
alu_a_o / alu_b_o  out  XLEN  registered ALU operands
ex_store_data_o  out  XLEN  forwarded rs2 value for stores
ex_pc_o  out  XLEN  registered PC
ex_rd_o  out  REG_ADDR_W  registered rd
ex_reg_write_o  out  1  registered reg-write enable (0 in bubbles)
ex_is_load_o  out  1  registered load flag

Behaviour:
- Reset values:
  - ex_valid_o=0, alu_op_o=ALU_NONE, ex_reg_write_o=0, ex_is_load_o=0.
  - alu_a_o, alu_b_o, ex_store_data_o, ex_pc_o and ex_rd_o all reset to 0.
  - id_ready_o=0 while rst_i=1.
- Reset mid-operation discards everything. The first accept is possible in the first cycle after rst_i falls.
- slot_free = !ex_valid_o | ex_ready_i.
- Load-use hazard: load_use = id_valid_i & ex_valid_o & ex_is_load_o & ex_rd_o!=0, and rd matches either (id_uses_rs1_i & id_rs1_i==ex_rd_o) or (id_uses_rs2_i & id_rs2_i==ex_rd_o).
- id_ready_o = !rst_i & (flush_i | (slot_free & !load_use)).
- Forwarding is resolved per source at capture time; priority is highest first:
  - EX: ex_valid_o & ex_reg_write_o & !ex_is_load_o & ex_rd_o==rs → ex_result_i.
  - MEM: mem_fwd_valid_i & mem_rd_i==rs → mem_result_i.
  - Otherwise the register-file data.
  - Index 0 is never forwarded; its value is always the rf data (0).
- Operand select:
  - alu_a_o = id_a_pc_i ? id_pc_i : fwd_rs1.
  - alu_b_o = id_b_imm_i ? id_imm_i : fwd_rs2.
  - ex_store_data_o = fwd_rs2.
  - b is passed unmodified for shifts; the ALU uses only b[4:0].
- Register update, evaluated in priority order:
  1. rst_i: reset values.
  2. flush_i: ex_valid_o=0, ex_reg_write_o=0, ex_is_load_o=0, alu_op_o=ALU_NONE. The ID instruction is consumed and dropped.
  3. !slot_free: all outputs hold (downstream stall). ex_result_i stays consistent because the operands hold.
  4. slot_free & load_use: bubble. ex_valid_o=0, ex_reg_write_o=0, ex_is_load_o=0, alu_op_o=ALU_NONE. ID is not accepted; the next cycle re-evaluates with the load in MEM via mem_fwd_valid_i.
  5. slot_free & id_valid_i: capture all fields, ex_valid_o=1.
  6. slot_free & !id_valid_i: ex_valid_o=0, ex_reg_write_o=0, alu_op_o=ALU_NONE.
- Latency: one cycle from accept to alu_*_o. Back-to-back throughput is 1 instruction per cycle when there is no hazard or stall.
- Simultaneous flush_i and ex_ready_i=0: the flush wins.
- Simultaneous EX and MEM match on the same rs: the EX value is used (younger result).

Test Plan:
- Back-to-back dependency:
  - Stimulus: ADD x5=x1+x2 (rf 3,4), then SUB x6=x5-x1.
  - Required response: cycle 1 alu_a_o=3, alu_b_o=4; cycle 2 alu_a_o=7 (EX forward, not the stale rf value), alu_op_o=ALU_SUB.
- Load-use:
  - Stimulus: LW x7 in EX, then ADD x8=x7+x0 offered.
  - Required response: id_ready_o=0 for one cycle and a bubble with ex_valid_o=0. Next cycle, with mem_fwd_valid_i=1, mem_rd_i=7, mem_result_i=0xDEAD, the stage captures alu_a_o=0xDEAD.
- x0 guard:
  - Stimulus: EX holds a write to rd=0 with result 0x55; next instruction reads x0.
  - Required response: operand = 0, not forwarded.
- Downstream stall:
  - Stimulus: ex_ready_i=0 for 3 cycles while id_valid_i=1.
  - Required response: all ex_*/alu_* outputs stable, id_ready_o=0. Capture happens on the cycle ex_ready_i returns to 1.
- Flush during stall:
  - Stimulus: ex_valid_o=1, ex_ready_i=0, flush_i=1.
  - Required response: next cycle ex_valid_o=0, ex_reg_write_o=0, alu_op_o=ALU_NONE; id_ready_o=1 during the flush cycle.
- Immediate/PC select:
  - Stimulus: AUIPC with PC=0x1000, imm=0x2000.
  - Required response: alu_a_o=0x1000, alu_b_o=0x2000, regardless of rs1/rs2 forwarding matches.

Source files
------------

// File: rtl/ex_operand_stage.sv
// Decode-to-execute pipeline register with operand forwarding, operand select and load-use bubble insertion.
// Latency: one cycle from ID accept to registered ALU op/operands; 1 instruction/cycle when there is no hazard or stall.
// Backpressure: holds all outputs while ex_ready_i=0; drops id_ready_o on stall or load-use; flush always accepts and drops.
module ex_operand_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_OP_W   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  id_valid_i,
  output logic                  id_ready_o,
  input  logic [ALU_OP_W-1:0]   id_alu_op_i,
  input  logic [XLEN-1:0]       id_pc_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_uses_rs1_i,
  input  logic                  id_uses_rs2_i,
  input  logic [XLEN-1:0]       id_rs1_data_i,
  input  logic [XLEN-1:0]       id_rs2_data_i,
  input  logic [XLEN-1:0]       id_imm_i,
  input  logic                  id_a_pc_i,
  input  logic                  id_b_imm_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_reg_write_i,
  input  logic                  id_is_load_i,
  input  logic [XLEN-1:0]       ex_result_i,
  input  logic                  mem_fwd_valid_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  input  logic [XLEN-1:0]       mem_result_i,
  output logic                  ex_valid_o,
  input  logic                  ex_ready_i,
  output logic [ALU_OP_W-1:0]   alu_op_o,
  output logic [XLEN-1:0]       alu_a_o,
  output logic [XLEN-1:0]       alu_b_o,
  output logic [XLEN-1:0]       ex_store_data_o,
  output logic [XLEN-1:0]       ex_pc_o,
  output logic [REG_ADDR_W-1:0] ex_rd_o,
  output logic                  ex_reg_write_o,
  output logic                  ex_is_load_o
);

  // Bubble / reset encoding of the ALU op.
  localparam logic [ALU_OP_W-1:0] ALU_NONE = '0;

  logic                  ex_valid_q, ex_valid_d;
  logic [ALU_OP_W-1:0]   alu_op_q, alu_op_d;
  logic [XLEN-1:0]       alu_a_q, alu_a_d;
  logic [XLEN-1:0]       alu_b_q, alu_b_d;
  logic [XLEN-1:0]       store_q, store_d;
  logic [XLEN-1:0]       pc_q, pc_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  reg_write_q, reg_write_d;
  logic                  is_load_q, is_load_d;

  logic                  slot_free;
  logic                  load_use;
  logic                  ex_fwd_en;
  logic [XLEN-1:0]       fwd_rs1;
  logic [XLEN-1:0]       fwd_rs2;

  // Forwarding mux for one source: EX (younger) beats MEM, x0 is never forwarded.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [XLEN-1:0]       rf_data,
    input logic                  ex_en,
    input logic [REG_ADDR_W-1:0] ex_rd,
    input logic [XLEN-1:0]       ex_res,
    input logic                  mem_en,
    input logic [REG_ADDR_W-1:0] mem_rd,
    input logic [XLEN-1:0]       mem_res
  );
    logic [XLEN-1:0] v;
    v = rf_data;
    if (rs != '0) begin
      if (ex_en && (ex_rd == rs)) begin
        v = ex_res;
      end else if (mem_en && (mem_rd == rs)) begin
        v = mem_res;
      end
    end
    return v;
  endfunction

  // Handshake, hazard detection and forwarded source values.
  always_comb begin
    slot_free  = !ex_valid_q || ex_ready_i;
    load_use   = id_valid_i && ex_valid_q && is_load_q && (rd_q != '0) &&
                 ((id_uses_rs1_i && (id_rs1_i == rd_q)) ||
                  (id_uses_rs2_i && (id_rs2_i == rd_q)));
    id_ready_o = !rst_i && (flush_i || (slot_free && !load_use));
    // A load in EX has no result yet; its value arrives through MEM next cycle.
    ex_fwd_en  = ex_valid_q && reg_write_q && !is_load_q;
    fwd_rs1    = fwd_sel(id_rs1_i, id_rs1_data_i, ex_fwd_en, rd_q, ex_result_i,
                         mem_fwd_valid_i, mem_rd_i, mem_result_i);
    fwd_rs2    = fwd_sel(id_rs2_i, id_rs2_data_i, ex_fwd_en, rd_q, ex_result_i,
                         mem_fwd_valid_i, mem_rd_i, mem_result_i);
  end

  // Next-state selection: flush, stall hold, bubble, capture, or idle.
  always_comb begin
    ex_valid_d  = ex_valid_q;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    store_d     = store_q;
    pc_d        = pc_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    is_load_d   = is_load_q;
    if (flush_i) begin
      ex_valid_d  = 1'b0;
      reg_write_d = 1'b0;
      is_load_d   = 1'b0;
      alu_op_d    = ALU_NONE;
    end else if (!slot_free) begin
      // Downstream stall: operands hold, so ex_result_i stays consistent.
    end else if (load_use) begin
      ex_valid_d  = 1'b0;
      reg_write_d = 1'b0;
      is_load_d   = 1'b0;
      alu_op_d    = ALU_NONE;
    end else if (id_valid_i) begin
      ex_valid_d  = 1'b1;
      alu_op_d    = id_alu_op_i;
      alu_a_d     = id_a_pc_i  ? id_pc_i  : fwd_rs1;
      alu_b_d     = id_b_imm_i ? id_imm_i : fwd_rs2;
      store_d     = fwd_rs2;
      pc_d        = id_pc_i;
      rd_d        = id_rd_i;
      reg_write_d = id_reg_write_i;
      is_load_d   = id_is_load_i;
    end else begin
      ex_valid_d  = 1'b0;
      reg_write_d = 1'b0;
      alu_op_d    = ALU_NONE;
    end
  end

  // EX-slot register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid_q  <= 1'b0;
      alu_op_q    <= ALU_NONE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      store_q     <= '0;
      pc_q        <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      is_load_q   <= 1'b0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      store_q     <= store_d;
      pc_q        <= pc_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      is_load_q   <= is_load_d;
    end
  end

  assign ex_valid_o      = ex_valid_q;
  assign alu_op_o        = alu_op_q;
  assign alu_a_o         = alu_a_q;
  assign alu_b_o         = alu_b_q;
  assign ex_store_data_o = store_q;
  assign ex_pc_o         = pc_q;
  assign ex_rd_o         = rd_q;
  assign ex_reg_write_o  = reg_write_q;
  assign ex_is_load_o    = is_load_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: forwarding, load-use bubble, x0 guard, stall, flush, operand select, reset.
module tb_ex_operand_stage;

  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        id_valid_i;
  logic        id_ready_o;
  logic [3:0]  id_alu_op_i;
  logic [31:0] id_pc_i;
  logic [4:0]  id_rs1_i, id_rs2_i;
  logic        id_uses_rs1_i, id_uses_rs2_i;
  logic [31:0] id_rs1_data_i, id_rs2_data_i;
  logic [31:0] id_imm_i;
  logic        id_a_pc_i, id_b_imm_i;
  logic [4:0]  id_rd_i;
  logic        id_reg_write_i, id_is_load_i;
  logic [31:0] ex_result_i;
  logic        mem_fwd_valid_i;
  logic [4:0]  mem_rd_i;
  logic [31:0] mem_result_i;
  logic        ex_valid_o;
  logic        ex_ready_i;
  logic [3:0]  alu_op_o;
  logic [31:0] alu_a_o, alu_b_o, ex_store_data_o, ex_pc_o;
  logic [4:0]  ex_rd_o;
  logic        ex_reg_write_o, ex_is_load_o;

  int n_cmp = 0;
  int n_bad = 0;

  ex_operand_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
    .id_alu_op_i(id_alu_op_i), .id_pc_i(id_pc_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
    .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
    .id_imm_i(id_imm_i), .id_a_pc_i(id_a_pc_i), .id_b_imm_i(id_b_imm_i),
    .id_rd_i(id_rd_i), .id_reg_write_i(id_reg_write_i), .id_is_load_i(id_is_load_i),
    .ex_result_i(ex_result_i),
    .mem_fwd_valid_i(mem_fwd_valid_i), .mem_rd_i(mem_rd_i), .mem_result_i(mem_result_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .ex_store_data_o(ex_store_data_o), .ex_pc_o(ex_pc_o), .ex_rd_o(ex_rd_o),
    .ex_reg_write_o(ex_reg_write_o), .ex_is_load_o(ex_is_load_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic offer(input logic [3:0] op, input logic [31:0] pc,
                       input logic [4:0] rs1, input logic u1, input logic [31:0] d1,
                       input logic [4:0] rs2, input logic u2, input logic [31:0] d2,
                       input logic [31:0] imm, input logic apc, input logic bimm,
                       input logic [4:0] rd, input logic rw, input logic ld);
    id_valid_i = 1'b1; id_alu_op_i = op; id_pc_i = pc;
    id_rs1_i = rs1; id_uses_rs1_i = u1; id_rs1_data_i = d1;
    id_rs2_i = rs2; id_uses_rs2_i = u2; id_rs2_data_i = d2;
    id_imm_i = imm; id_a_pc_i = apc; id_b_imm_i = bimm;
    id_rd_i = rd; id_reg_write_i = rw; id_is_load_i = ld;
  endtask

  task automatic set_mem(input logic v, input logic [4:0] rd, input logic [31:0] res);
    mem_fwd_valid_i = v; mem_rd_i = rd; mem_result_i = res;
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; ex_ready_i = 1'b1; ex_result_i = '0;
    set_mem(1'b0, 5'd0, 32'd0);
    offer(ALU_ADD, 32'h100, 5'd1, 1'b1, 32'd3, 5'd2, 1'b1, 32'd4, 32'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);

    // Reset state, with an instruction already offered.
    tick(); tick();
    check("rst_id_ready", {31'd0, id_ready_o}, 32'd0);
    check("rst_ex_valid", {31'd0, ex_valid_o}, 32'd0);
    check("rst_alu_op", {28'd0, alu_op_o}, {28'd0, ALU_NONE});
    check("rst_reg_write", {31'd0, ex_reg_write_o}, 32'd0);
    check("rst_is_load", {31'd0, ex_is_load_o}, 32'd0);
    check("rst_alu_a", alu_a_o, 32'd0);
    check("rst_alu_b", alu_b_o, 32'd0);
    check("rst_store", ex_store_data_o, 32'd0);
    check("rst_pc", ex_pc_o, 32'd0);
    check("rst_rd", {27'd0, ex_rd_o}, 32'd0);

    // ADD x5 = x1 + x2 accepted in the first cycle out of reset.
    rst_i = 1'b0; #1;
    check("add_id_ready", {31'd0, id_ready_o}, 32'd1);
    tick();
    check("add_valid", {31'd0, ex_valid_o}, 32'd1);
    check("add_a", alu_a_o, 32'd3);
    check("add_b", alu_b_o, 32'd4);
    check("add_op", {28'd0, alu_op_o}, {28'd0, ALU_ADD});
    check("add_rd", {27'd0, ex_rd_o}, 32'd5);
    check("add_pc", ex_pc_o, 32'h100);
    ex_result_i = 32'd7;

    // SUB x6 = x5 - x1: x5 comes from EX, not the stale rf value.
    offer(ALU_SUB, 32'h104, 5'd5, 1'b1, 32'h99, 5'd1, 1'b1, 32'd3, 32'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0);
    tick();
    check("sub_a_exfwd", alu_a_o, 32'd7);
    check("sub_b", alu_b_o, 32'd3);
    check("sub_op", {28'd0, alu_op_o}, {28'd0, ALU_SUB});
    ex_result_i = 32'd4;

    // LW x7, 8(x1).
    offer(ALU_ADD, 32'h108, 5'd1, 1'b1, 32'd3, 5'd0, 1'b0, 32'd0, 32'd8, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1);
    tick();
    check("lw_is_load", {31'd0, ex_is_load_o}, 32'd1);
    check("lw_a", alu_a_o, 32'd3);
    check("lw_b", alu_b_o, 32'd8);
    ex_result_i = 32'd11;

    // ADD x8 = x7 + x0 right behind the load: one bubble.
    offer(ALU_ADD, 32'h10C, 5'd7, 1'b1, 32'h5, 5'd0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0);
    #1;
    check("lu_id_ready", {31'd0, id_ready_o}, 32'd0);
    tick();
    check("lu_bubble_valid", {31'd0, ex_valid_o}, 32'd0);
    check("lu_bubble_rw", {31'd0, ex_reg_write_o}, 32'd0);
    check("lu_bubble_op", {28'd0, alu_op_o}, {28'd0, ALU_NONE});
    set_mem(1'b1, 5'd7, 32'hDEAD);
    #1;
    check("lu_retry_ready", {31'd0, id_ready_o}, 32'd1);
    tick();
    check("lu_valid", {31'd0, ex_valid_o}, 32'd1);
    check("lu_a_memfwd", alu_a_o, 32'hDEAD);
    check("lu_b_x0", alu_b_o, 32'd0);
    set_mem(1'b0, 5'd0, 32'd0);

    // Write to x0 in EX with result 0x55; the next reader of x0 must see 0.
    offer(ALU_ADD, 32'h110, 5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'h55, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0);
    tick();
    ex_result_i = 32'h55;
    set_mem(1'b1, 5'd0, 32'h77);
    offer(ALU_ADD, 32'h114, 5'd0, 1'b1, 32'd0, 5'd0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 5'd12, 1'b1, 1'b0);
    tick();
    check("x0_a", alu_a_o, 32'd0);
    check("x0_b", alu_b_o, 32'd0);
    check("x0_store", ex_store_data_o, 32'd0);
    set_mem(1'b0, 5'd0, 32'd0);

    // EX and MEM both match x9: EX (younger) wins on both sources.
    offer(ALU_ADD, 32'h118, 5'd1, 1'b1, 32'd3, 5'd0, 1'b0, 32'd0, 32'h10E, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0);
    tick();
    ex_result_i = 32'h111;
    set_mem(1'b1, 5'd9, 32'h222);
    offer(ALU_SUB, 32'h11C, 5'd9, 1'b1, 32'hAAA, 5'd9, 1'b1, 32'hAAA, 32'd0, 1'b0, 1'b0, 5'd10, 1'b1, 1'b0);
    tick();
    check("prio_a", alu_a_o, 32'h111);
    check("prio_b", alu_b_o, 32'h111);
    check("prio_store", ex_store_data_o, 32'h111);
    set_mem(1'b0, 5'd0, 32'd0);
    ex_result_i = 32'd0;

    // Downstream stall for 3 cycles with a new instruction waiting.
    ex_ready_i = 1'b0;
    offer(ALU_ADD, 32'h200, 5'd2, 1'b1, 32'd4, 5'd1, 1'b1, 32'd3, 32'd0, 1'b0, 1'b0, 5'd11, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_id_ready", {31'd0, id_ready_o}, 32'd0);
      tick();
      check("stall_valid", {31'd0, ex_valid_o}, 32'd1);
      check("stall_a", alu_a_o, 32'h111);
      check("stall_b", alu_b_o, 32'h111);
      check("stall_op", {28'd0, alu_op_o}, {28'd0, ALU_SUB});
      check("stall_rd", {27'd0, ex_rd_o}, 32'd10);
      check("stall_pc", ex_pc_o, 32'h11C);
    end
    ex_ready_i = 1'b1; #1;
    check("unstall_id_ready", {31'd0, id_ready_o}, 32'd1);
    tick();
    check("unstall_a", alu_a_o, 32'd4);
    check("unstall_b", alu_b_o, 32'd3);
    check("unstall_rd", {27'd0, ex_rd_o}, 32'd11);
    check("unstall_pc", ex_pc_o, 32'h200);

    // Flush while stalled: flush wins, ID is consumed.
    ex_ready_i = 1'b0; flush_i = 1'b1;
    offer(ALU_SUB, 32'h204, 5'd3, 1'b1, 32'd1, 5'd4, 1'b1, 32'd2, 32'd0, 1'b0, 1'b0, 5'd13, 1'b1, 1'b0);
    #1;
    check("flush_id_ready", {31'd0, id_ready_o}, 32'd1);
    tick();
    check("flush_valid", {31'd0, ex_valid_o}, 32'd0);
    check("flush_rw", {31'd0, ex_reg_write_o}, 32'd0);
    check("flush_op", {28'd0, alu_op_o}, {28'd0, ALU_NONE});
    flush_i = 1'b0; ex_ready_i = 1'b1;

    // AUIPC: PC and immediate win over a matching MEM forward; store data still forwards.
    set_mem(1'b1, 5'd3, 32'h333);
    offer(ALU_ADD, 32'h1000, 5'd3, 1'b1, 32'h5, 5'd3, 1'b1, 32'h5, 32'h2000, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0);
    tick();
    check("auipc_a", alu_a_o, 32'h1000);
    check("auipc_b", alu_b_o, 32'h2000);
    check("auipc_store", ex_store_data_o, 32'h333);
    check("auipc_pc", ex_pc_o, 32'h1000);
    set_mem(1'b0, 5'd0, 32'd0);

    // Nothing offered: EX slot empties.
    id_valid_i = 1'b0;
    tick();
    check("idle_valid", {31'd0, ex_valid_o}, 32'd0);
    check("idle_rw", {31'd0, ex_reg_write_o}, 32'd0);
    check("idle_op", {28'd0, alu_op_o}, {28'd0, ALU_NONE});

    // Reset mid-operation discards the slot; accept resumes right after.
    offer(ALU_SUB, 32'h300, 5'd1, 1'b1, 32'd9, 5'd2, 1'b1, 32'd5, 32'd0, 1'b0, 1'b0, 5'd15, 1'b1, 1'b0);
    tick();
    check("pre_rst_valid", {31'd0, ex_valid_o}, 32'd1);
    rst_i = 1'b1; #1;
    check("mid_rst_id_ready", {31'd0, id_ready_o}, 32'd0);
    tick();
    check("mid_rst_valid", {31'd0, ex_valid_o}, 32'd0);
    check("mid_rst_a", alu_a_o, 32'd0);
    check("mid_rst_rd", {27'd0, ex_rd_o}, 32'd0);
    rst_i = 1'b0; #1;
    check("post_rst_id_ready", {31'd0, id_ready_o}, 32'd1);
    tick();
    check("post_rst_valid", {31'd0, ex_valid_o}, 32'd1);
    check("post_rst_a", alu_a_o, 32'd9);
    check("post_rst_b", alu_b_o, 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
